// File: rtl/lda_pipe.sv
// Bresenham line engine: two endpoints in, one pixel per accepted cycle out on a valid/ready plot port.
// Define LDA_CLIP_EN to suppress pixels beyond XMAX/YMAX without stalling the traversal.
module lda_pipe #(
    parameter int XW   = 9,
    parameter int YW   = 8,
    parameter int CW   = 3,
    parameter int XMAX = 319,
    parameter int YMAX = 239
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [XW-1:0] x0_in,
    input  logic [YW-1:0] y0_in,
    input  logic [XW-1:0] x1_in,
    input  logic [YW-1:0] y1_in,
    input  logic [CW-1:0] colour_in,
    output logic          plot,
    input  logic          plot_ready,
    output logic [XW-1:0] plot_x,
    output logic [YW-1:0] plot_y,
    output logic [CW-1:0] plot_colour,
    output logic          busy,
    output logic          done
);
    localparam int W  = (XW > YW) ? XW : YW;
    localparam int EW = W + 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_DRAW  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]           state;
    logic [W-1:0]         lx0, ly0, lx1, ly1;
    logic [CW-1:0]        col;
    logic [W-1:0]         x, y, xe;
    logic [W:0]           dx, dy;
    logic signed [EW-1:0] err;
    logic                 yneg, steep;

    // Setup datapath: fold octants into a shallow, left-to-right traversal.
    logic [W-1:0] dxa, dya, ax0, ay0, ax1, ay1, bx0, by0, bx1, by1;
    logic [W:0]   s_dx, s_dy;
    logic         s_steep, s_swap;

    always_comb begin
        dxa     = (lx1 >= lx0) ? lx1 - lx0 : lx0 - lx1;
        dya     = (ly1 >= ly0) ? ly1 - ly0 : ly0 - ly1;
        s_steep = dya > dxa;
        ax0     = s_steep ? ly0 : lx0;
        ay0     = s_steep ? lx0 : ly0;
        ax1     = s_steep ? ly1 : lx1;
        ay1     = s_steep ? lx1 : ly1;
        s_swap  = ax0 > ax1;
        bx0     = s_swap ? ax1 : ax0;
        by0     = s_swap ? ay1 : ay0;
        bx1     = s_swap ? ax0 : ax1;
        by1     = s_swap ? ay0 : ay1;
        s_dx    = {1'b0, bx1 - bx0};
        s_dy    = {1'b0, (by1 >= by0) ? by1 - by0 : by0 - by1};
    end

    logic [W-1:0]         px, py;
    logic                 vis, adv;
    logic signed [EW-1:0] err_n;

    always_comb begin
        px = steep ? y : x;
        py = steep ? x : y;
`ifdef LDA_CLIP_EN
        vis = (int'(px) <= XMAX) && (int'(py) <= YMAX);
`else
        vis = 1'b1;
`endif
        adv   = (state == S_DRAW) && (plot_ready || !vis);
        err_n = err + $signed({1'b0, dy});
    end

    assign plot        = (state == S_DRAW) && vis;
    assign plot_x      = px[XW-1:0];
    assign plot_y      = py[YW-1:0];
    assign plot_colour = col;
    assign busy        = (state == S_SETUP) || (state == S_DRAW);
    assign done        = (state == S_DONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            lx0   <= '0;
            ly0   <= '0;
            lx1   <= '0;
            ly1   <= '0;
            col   <= '0;
            x     <= '0;
            y     <= '0;
            xe    <= '0;
            dx    <= '0;
            dy    <= '0;
            err   <= '0;
            yneg  <= 1'b0;
            steep <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    lx0   <= W'(x0_in);
                    ly0   <= W'(y0_in);
                    lx1   <= W'(x1_in);
                    ly1   <= W'(y1_in);
                    col   <= colour_in;
                    state <= S_SETUP;
                end
                S_SETUP: begin
                    steep <= s_steep;
                    x     <= bx0;
                    y     <= by0;
                    xe    <= bx1;
                    dx    <= s_dx;
                    dy    <= s_dy;
                    err   <= -$signed({1'b0, s_dx >> 1});
                    yneg  <= by0 > by1;
                    state <= S_DRAW;
                end
                S_DRAW: if (adv) begin
                    if (x == xe) begin
                        state <= S_DONE;
                    end else begin
                        x <= x + 1'b1;
                        if (err_n > 0) begin
                            err <= err_n - $signed({1'b0, dx});
                            y   <= yneg ? y - 1'b1 : y + 1'b1;
                        end else begin
                            err <= err_n;
                        end
                    end
                end
                default: if (!start) state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lda_pipe.sv
// Bench for lda_pipe: directed line table, backpressure/reset sequences, random lines vs a closed-form model.
module tb_lda_pipe;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [8:0] x0_in = '0, x1_in = '0;
    logic [7:0] y0_in = '0, y1_in = '0;
    logic [2:0] colour_in = '0;
    logic       plot, plot_ready = 1'b0;
    logic [8:0] plot_x;
    logic [7:0] plot_y;
    logic [2:0] plot_colour;
    logic       busy, done;

    lda_pipe dut (
        .clk(clk), .resetn(resetn), .start(start),
        .x0_in(x0_in), .y0_in(y0_in), .x1_in(x1_in), .y1_in(y1_in),
        .colour_in(colour_in), .plot(plot), .plot_ready(plot_ready),
        .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int gx[$], gy[$];   // pixels accepted from the DUT
    int mx[$], my[$];   // full traversal from the model
    int ex[$], ey[$];   // expected visible pixels

    typedef struct {
        int x0, y0, x1, y1, col, mode, n;
        logic [3:0][8:0] px;
        logic [3:0][7:0] py;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string nm, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    function automatic bit visible(input int x, input int y);
`ifdef LDA_CLIP_EN
        return (x <= 319) && (y <= 239);
`else
        return (x >= 0) && (y >= 0);
`endif
    endfunction

    function automatic vec_t mk(input int x0, y0, x1, y1, col, mode, n,
                                input int a0, b0, a1, b1, a2, b2, a3, b3);
        vec_t v;
        v.x0 = x0; v.y0 = y0; v.x1 = x1; v.y1 = y1;
        v.col = col; v.mode = mode; v.n = n;
        v.px[0] = 9'(a0); v.py[0] = 8'(b0);
        v.px[1] = 9'(a1); v.py[1] = 8'(b1);
        v.px[2] = 9'(a2); v.py[2] = 8'(b2);
        v.px[3] = 9'(a3); v.py[3] = 8'(b3);
        return v;
    endfunction

    // Closed form: after i steps the minor axis has moved ceil((i*dy - dx/2)/dx) units.
    task automatic model(input int x0, y0, x1, y1);
        int dxa, dya, dx, dy, h, s, k, t;
        bit st;
        mx.delete(); my.delete();
        dxa = (x1 > x0) ? x1 - x0 : x0 - x1;
        dya = (y1 > y0) ? y1 - y0 : y0 - y1;
        st = dya > dxa;
        if (st) begin
            t = x0; x0 = y0; y0 = t;
            t = x1; x1 = y1; y1 = t;
        end
        if (x0 > x1) begin
            t = x0; x0 = x1; x1 = t;
            t = y0; y0 = y1; y1 = t;
        end
        dx = x1 - x0;
        dy = (y1 > y0) ? y1 - y0 : y0 - y1;
        h  = dx / 2;
        s  = (y0 < y1) ? 1 : -1;
        for (int i = 0; i <= dx; i++) begin
            k = (dx == 0) ? 0 : (i * dy - h + dx - 1) / dx;
            if (st) begin mx.push_back(y0 + s * k); my.push_back(x0 + i); end
            else    begin mx.push_back(x0 + i);     my.push_back(y0 + s * k); end
        end
    endtask

    task automatic cmp_px(input string nm);
        int n;
        chk({nm, "_count"}, gx.size(), ex.size());
        n = (gx.size() < ex.size()) ? gx.size() : ex.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_px%0d_x", nm, i), gx[i], ex[i]);
            chk($sformatf("%s_px%0d_y", nm, i), gy[i], ey[i]);
        end
    endtask

    // mode 0: ready always; 1: random ready; 2: ready dropped 3 cycles at the second pixel
    task automatic run_line(input int x0, y0, x1, y1, col, mode,
                            output int busy_n, output int stalls);
        bit first, prev_stall, rdy;
        int hx, hy, drops;
        gx.delete(); gy.delete();
        busy_n = 0; stalls = 0; first = 1; prev_stall = 0; drops = 0; hx = 0; hy = 0;
        @(negedge clk);
        x0_in = 9'(x0); y0_in = 8'(y0); x1_in = 9'(x1); y1_in = 8'(y1);
        colour_in = 3'(col); start = 1'b1; plot_ready = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done) break;
            if (busy) busy_n++;
            if (first) begin
                chk("setup_no_plot", int'(plot), 0);
                first = 0;
            end
            if (prev_stall) begin
                chk("hold_plot", int'(plot), 1);
                chk("hold_x", int'(plot_x), hx);
                chk("hold_y", int'(plot_y), hy);
            end
            if (plot) chk("colour", int'(plot_colour), col);
            case (mode)
                0: rdy = 1'b1;
                1: rdy = ($urandom_range(3) != 0);
                default: begin
                    rdy = !(plot && gx.size() == 1 && drops < 3);
                    if (!rdy) drops++;
                end
            endcase
            plot_ready = rdy;
            prev_stall = plot && !rdy;
            hx = int'(plot_x); hy = int'(plot_y);
            if (plot && rdy) begin gx.push_back(hx); gy.push_back(hy); end
            if (plot && !rdy) stalls++;
        end
        chk("done_reached", int'(done), 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("done_held", int'(done), 1);
            chk("no_redraw", int'(plot | busy), 0);
        end
        start = 1'b0;
        @(negedge clk);
        chk("back_idle", int'(done | busy), 0);
    endtask

    task automatic build_exp_from_model();
        ex.delete(); ey.delete();
        foreach (mx[i]) if (visible(mx[i], my[i])) begin
            ex.push_back(mx[i]); ey.push_back(my[i]);
        end
    endtask

    initial begin
        int bn, st, x0, y0, x1, y1, col;
        bit found;

        tbl[0] = mk(0, 0, 3, 0, 5, 0, 4,  0, 0, 1, 0, 2, 0, 3, 0);
        tbl[1] = mk(0, 0, 1, 3, 2, 0, 4,  0, 0, 0, 1, 1, 2, 1, 3);
        tbl[2] = mk(3, 2, 0, 0, 7, 0, 4,  0, 0, 1, 1, 2, 1, 3, 2);
        tbl[3] = mk(0, 0, 2, 2, 4, 2, 3,  0, 0, 1, 1, 2, 2, 0, 0);
        tbl[4] = mk(5, 5, 5, 5, 1, 0, 1,  5, 5, 0, 0, 0, 0, 0, 0);
        tbl[5] = mk(0, 3, 3, 0, 6, 1, 4,  0, 3, 1, 2, 2, 1, 3, 0);

        repeat (3) @(negedge clk);
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_xy", int'(plot_x) + int'(plot_y) + int'(plot_colour), 0);
        resetn = 1'b1;

        foreach (tbl[i]) begin
            ex.delete(); ey.delete();
            for (int j = 0; j < tbl[i].n; j++) begin
                ex.push_back(int'(tbl[i].px[j])); ey.push_back(int'(tbl[i].py[j]));
            end
            run_line(tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1, tbl[i].col, tbl[i].mode, bn, st);
            cmp_px($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_busy", i), bn, 1 + tbl[i].n + st);
            if (tbl[i].mode == 2) chk("bp_stalls", st, 3);
        end

        // Reset in the middle of a 10-pixel line.
        @(negedge clk);
        x0_in = 9'd0; y0_in = 8'd0; x1_in = 9'd9; y1_in = 8'd0; colour_in = 3'd3;
        start = 1'b1; plot_ready = 1'b1; found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (plot && plot_x == 9'd1) found = 1;
        end
        chk("mid_reached", int'(found), 1);
        resetn = 1'b0; start = 1'b0;
        #1;
        chk("midrst_plot", int'(plot), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_x", int'(plot_x), 0);
        chk("midrst_y", int'(plot_y), 0);
        chk("midrst_col", int'(plot_colour), 0);
        @(negedge clk);
        resetn = 1'b1;
        model(2, 7, 11, 3);
        build_exp_from_model();
        run_line(2, 7, 11, 3, 6, 0, bn, st);
        cmp_px("after_rst");
        chk("after_rst_busy", bn, 1 + mx.size() + st);

`ifdef LDA_CLIP_EN
        model(318, 10, 321, 10);
        build_exp_from_model();
        run_line(318, 10, 321, 10, 2, 0, bn, st);
        cmp_px("clip");
        chk("clip_busy", bn, 5);
`endif

        for (int r = 0; r < 30; r++) begin
            x0 = $urandom_range(511); y0 = $urandom_range(255);
            x1 = $urandom_range(511); y1 = $urandom_range(255);
            if (r < 10) begin
                x1 = (x0 + $urandom_range(12)) % 512;
                y1 = (y0 + $urandom_range(12)) % 256;
            end
            col = $urandom_range(7);
            model(x0, y0, x1, y1);
            build_exp_from_model();
            run_line(x0, y0, x1, y1, col, 1, bn, st);
            cmp_px($sformatf("rnd%0d", r));
            chk($sformatf("rnd%0d_busy", r), bn, 1 + mx.size() + st);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
